// File: rtl/cr_huf_comp_st_rle_encoder_pkg.sv
// Shared types and constants for the ST code-length run-length encoder.
// Holds the state enum, the sym_buf entry layout and the code-length alphabet constants.
package cr_huf_compPKG;

  typedef enum logic [1:0] {
    ST_RLE_IDLE,
    ST_RLE_RUN,
    ST_RLE_EMIT,
    ST_RLE_DONE
  } e_st_rle_state;

  typedef struct packed {
    logic [4:0] symbol;
    logic [7:0] extra;
    logic [3:0] extra_length;
    logic       val;
  } s_st_sym_buf_intf;

  localparam int NUM_ST_SYMS = 19;

  localparam logic [4:0] ST_SYM_REP_PREV = 5'd16;
  localparam logic [4:0] ST_SYM_REP_Z3   = 5'd17;
  localparam logic [4:0] ST_SYM_REP_Z11  = 5'd18;

  localparam logic [7:0] ST_RUN_CAP_ZERO = 8'd138;
  localparam logic [7:0] ST_RUN_CAP_NZ   = 8'd7;

  // Shortest run each repeat symbol can encode; doubles as its extra-field bias.
  localparam logic [7:0] ST_MIN_REP_PREV = 8'd3;
  localparam logic [7:0] ST_MIN_REP_Z3   = 8'd3;
  localparam logic [7:0] ST_MIN_REP_Z11  = 8'd11;

  localparam logic [3:0] ST_XLEN_REP_PREV = 4'd2;
  localparam logic [3:0] ST_XLEN_REP_Z3   = 4'd3;
  localparam logic [3:0] ST_XLEN_REP_Z11  = 4'd7;

endpackage

// File: rtl/cr_huf_comp_st_rle_emit.sv
// Combinational run emitter: given a run (value, count, first-literal pending)
// returns the next code-length-alphabet entry and the count still to encode.
module cr_huf_comp_st_rle_emit
  import cr_huf_compPKG::*;
(
  input  logic [3:0]       run_val,
  input  logic [7:0]       run_cnt,
  input  logic             first,
  output s_st_sym_buf_intf entry,
  output logic [7:0]       residual
);

  always_comb begin
    entry              = '0;
    entry.val          = 1'b1;
    entry.symbol       = {1'b0, run_val};
    residual           = run_cnt - 8'd1;
    if (run_val == 4'd0) begin
      if (run_cnt >= ST_MIN_REP_Z11) begin
        entry.symbol       = ST_SYM_REP_Z11;
        entry.extra        = run_cnt - ST_MIN_REP_Z11;
        entry.extra_length = ST_XLEN_REP_Z11;
        residual           = 8'd0;
      end else if (run_cnt >= ST_MIN_REP_Z3) begin
        entry.symbol       = ST_SYM_REP_Z3;
        entry.extra        = run_cnt - ST_MIN_REP_Z3;
        entry.extra_length = ST_XLEN_REP_Z3;
        residual           = 8'd0;
      end
    // A nonzero run must lead with its literal before "repeat previous" can apply.
    end else if (!first && (run_cnt >= ST_MIN_REP_PREV)) begin
      entry.symbol       = ST_SYM_REP_PREV;
      entry.extra        = run_cnt - ST_MIN_REP_PREV;
      entry.extra_length = ST_XLEN_REP_PREV;
      residual           = 8'd0;
    end
  end

endmodule

// File: rtl/cr_huf_comp_st_rle_encoder.sv
// Run-length encodes a Huffman code-length list into sym_buf entries and
// keeps the per-symbol histogram consumed by the ST tree generator.
module cr_huf_comp_st_rle_encoder
  import cr_huf_compPKG::*;
#(
  parameter int  MAX_SYMBOL_TABLE_DEPTH = 584,
  parameter int  MAX_NUM_LENGTHS        = 320,
  parameter int  FREQ_W                 = 10,
  localparam int NL_W                   = $clog2(MAX_NUM_LENGTHS + 1),
  localparam int IDX_W                  = $clog2(MAX_SYMBOL_TABLE_DEPTH),
  localparam int PTR_W                  = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NL_W-1:0]                     num_lengths,
  input  logic                                abort,
  input  logic                                cl_in_val,
  input  logic [3:0]                          cl_in_data,
  output logic                                cl_in_rdy,
  output logic                                sym_buf_wr,
  output logic [IDX_W-1:0]                    sym_buf_wr_idx,
  output s_st_sym_buf_intf                    sym_buf_wr_entry,
  output logic [PTR_W-1:0]                    sym_buf_wr_ptr,
  output logic [NUM_ST_SYMS-1:0][FREQ_W-1:0]  st_sym_freq,
  output logic                                rle_done,
  output logic                                rle_overflow
);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MAX_SYMBOL_TABLE_DEPTH);

  e_st_rle_state    state, state_nxt;
  logic [NL_W-1:0]  remaining;
  logic [3:0]       run_val, snap_val;
  logic [7:0]       run_cnt, snap_cnt, emit_residual, run_cap;
  logic             run_started, final_q, flush_q, snap_first;
  logic             xfer, extend, last_len, emit_en, start_ok, vld_p0;
  s_st_sym_buf_intf emit_entry_p0;

  assign run_cap  = (run_val == 4'd0) ? ST_RUN_CAP_ZERO : ST_RUN_CAP_NZ;
  assign xfer     = cl_in_val & cl_in_rdy;
  assign extend   = run_started & (cl_in_data == run_val) & (run_cnt < run_cap);
  assign last_len = (remaining == NL_W'(1));
  assign start_ok = (state == ST_RLE_IDLE) & start & ~abort;
  assign vld_p0   = emit_en & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RLE_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RLE_IDLE: if (start) state_nxt = (num_lengths == '0) ? ST_RLE_DONE : ST_RLE_RUN;
      ST_RLE_RUN:  if (xfer && (last_len || (run_started && !extend))) state_nxt = ST_RLE_EMIT;
      ST_RLE_EMIT: begin
        if (emit_residual == 8'd0) begin
          if (flush_q)       state_nxt = ST_RLE_DONE;
          else if (!final_q) state_nxt = ST_RLE_RUN;
        end
      end
      ST_RLE_DONE: state_nxt = ST_RLE_IDLE;
      default:     state_nxt = ST_RLE_IDLE;
    endcase
    if (abort) state_nxt = ST_RLE_IDLE;
  end

  always_comb begin
    cl_in_rdy = 1'b0;
    emit_en   = 1'b0;
    case (state)
      ST_RLE_RUN:  cl_in_rdy = ~abort;
      ST_RLE_EMIT: emit_en   = 1'b1;
      default: ;
    endcase
  end

  cr_huf_comp_st_rle_emit u_emit (
    .run_val  (snap_val),
    .run_cnt  (snap_cnt),
    .first    (snap_first),
    .entry    (emit_entry_p0),
    .residual (emit_residual)
  );

  // Stage p0: run tracking and the snapshot the emitter drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      run_val     <= '0;
      run_cnt     <= '0;
      run_started <= 1'b0;
      final_q     <= 1'b0;
      flush_q     <= 1'b0;
      snap_val    <= '0;
      snap_cnt    <= '0;
      snap_first  <= 1'b0;
    end else begin
      case (state)
        ST_RLE_IDLE: begin
          if (start_ok) begin
            remaining   <= num_lengths;
            run_cnt     <= '0;
            run_started <= 1'b0;
            final_q     <= 1'b0;
            flush_q     <= 1'b0;
          end
        end
        ST_RLE_RUN: begin
          if (xfer) begin
            remaining <= remaining - NL_W'(1);
            if (extend) begin
              run_cnt <= run_cnt + 8'd1;
            end else begin
              run_val     <= cl_in_data;
              run_cnt     <= 8'd1;
              run_started <= 1'b1;
            end
            if (run_started && !extend) begin
              snap_val   <= run_val;
              snap_cnt   <= run_cnt;
              snap_first <= 1'b1;
            end
            // Last length with no closed run pending: the live run goes straight out.
            if (last_len) begin
              final_q <= 1'b1;
              if (!run_started || extend) begin
                snap_val   <= cl_in_data;
                snap_cnt   <= extend ? run_cnt + 8'd1 : 8'd1;
                snap_first <= 1'b1;
                flush_q    <= 1'b1;
              end
            end
          end
        end
        ST_RLE_EMIT: begin
          snap_cnt   <= emit_residual;
          snap_first <= 1'b0;
          if ((emit_residual == 8'd0) && final_q && !flush_q) begin
            snap_val   <= run_val;
            snap_cnt   <= run_cnt;
            snap_first <= 1'b1;
            flush_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered sym_buf write, pointer and histogram.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_buf_wr       <= 1'b0;
      sym_buf_wr_idx   <= '0;
      sym_buf_wr_entry <= '0;
      sym_buf_wr_ptr   <= '0;
      st_sym_freq      <= '0;
      rle_done         <= 1'b0;
      rle_overflow     <= 1'b0;
    end else begin
      sym_buf_wr <= 1'b0;
      rle_done   <= (state == ST_RLE_DONE) & ~abort;
      if (start_ok) begin
        sym_buf_wr_ptr <= '0;
        st_sym_freq    <= '0;
        rle_overflow   <= 1'b0;
      end else if (vld_p0) begin
        if (sym_buf_wr_ptr == PTR_FULL) begin
          rle_overflow <= 1'b1;
        end else begin
          sym_buf_wr       <= 1'b1;
          sym_buf_wr_idx   <= sym_buf_wr_ptr[IDX_W-1:0];
          sym_buf_wr_entry <= emit_entry_p0;
          sym_buf_wr_ptr   <= sym_buf_wr_ptr + PTR_W'(1);
          for (int s = 0; s < NUM_ST_SYMS; s++) begin
            if (emit_entry_p0.symbol == 5'(s)) st_sym_freq[s] <= st_sym_freq[s] + FREQ_W'(1);
          end
        end
      end
    end
  end

endmodule
